pb_irq_pio: RTL and testbench

Parametrised pushbutton/switch input port for the Qsys system, on the Avalon-MM bus.
- Per-bit 2-flop synchroniser and debounce filter.
- Edge-capture register and interrupt-mask register.
- Level interrupt output.
- Drop-in successor to the plain 4-bit input PIO: same register map at offset 0, plus IRQ capability.

---
 rtl/pb_irq_pio_pkg.sv | 22 ++
 rtl/pb_irq_pio_if.sv | 13 +
 rtl/pb_debounce_bit.sv | 60 ++++++
 rtl/pb_irq_pio.sv | 87 ++++++++
 tb/tb_pb_irq_pio.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pb_irq_pio_pkg.sv
// Shared constants and types for the pushbutton IRQ input port.
package pb_irq_pio_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 2;

   localparam logic [ADDR_W-1:0] ADDR_DATA = 2'd0;
   localparam logic [ADDR_W-1:0] ADDR_DIR  = 2'd1;
   localparam logic [ADDR_W-1:0] ADDR_MASK = 2'd2;
   localparam logic [ADDR_W-1:0] ADDR_EDGE = 2'd3;

   localparam int unsigned EDGE_RISING  = 0;
   localparam int unsigned EDGE_FALLING = 1;
   localparam int unsigned EDGE_ANY     = 2;

   typedef struct packed {
      logic              wr_en;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } av_wr_t;

endpackage

// File: rtl/pb_irq_pio_if.sv
// Avalon-MM slave bus bundle for the pushbutton IRQ input port.
interface pb_irq_pio_if;
   import pb_irq_pio_pkg::*;

   logic [ADDR_W-1:0] address;
   logic              chipselect;
   logic              write_n;
   logic [DATA_W-1:0] writedata;
   logic [DATA_W-1:0] readdata;

   modport master (output address, chipselect, write_n, writedata, input readdata);
   modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/pb_debounce_bit.sv
// One input bit: 2-flop synchroniser, debounce counter, filtered state and edge events.
module pb_debounce_bit #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic in_raw,
   output logic db,
   output logic rise_c,
   output logic fall_c
);

   logic meta_q;
   logic sync_q;
   logic upd_c;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= in_raw;
         sync_q <= meta_q;
      end
   end

   if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign upd_c = sync_q ^ db;
   end else begin : g_filter
      localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

      logic [CNT_W-1:0] cnt_q;

      assign upd_c = (sync_q != db) && (cnt_q == CNT_LAST);

      // Any return to the filtered level restarts the run; the count stops at CNT_LAST.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            cnt_q <= '0;
         end else if ((sync_q == db) || upd_c) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         db <= 1'b0;
      end else if (upd_c) begin
         db <= sync_q;
      end
   end

   assign rise_c = upd_c &  sync_q & ~db;
   assign fall_c = upd_c & ~sync_q &  db;

endmodule

// File: rtl/pb_irq_pio.sv
// Debounced pushbutton input port with edge capture, interrupt mask and level IRQ.
module pb_irq_pio
   import pb_irq_pio_pkg::*;
#(
   parameter int unsigned WIDTH           = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned EDGE_TYPE       = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   pb_irq_pio_if.slave      bus,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   logic [WIDTH-1:0]  db;
   logic [WIDTH-1:0]  rise_c;
   logic [WIDTH-1:0]  fall_c;
   logic [WIDTH-1:0]  edge_ev_c;
   logic [WIDTH-1:0]  clr_c;
   logic [WIDTH-1:0]  mask_q;
   logic [WIDTH-1:0]  edge_q;
   logic [DATA_W-1:0] rd_c;
   av_wr_t            wr_c;
   logic              unused_wr;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      pb_debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk     (clk),
         .reset_n (reset_n),
         .in_raw  (in_port[i]),
         .db      (db[i]),
         .rise_c  (rise_c[i]),
         .fall_c  (fall_c[i])
      );
   end

   always_comb begin
      edge_ev_c = rise_c | fall_c;
      if (EDGE_TYPE == EDGE_RISING) begin
         edge_ev_c = rise_c;
      end else if (EDGE_TYPE == EDGE_FALLING) begin
         edge_ev_c = fall_c;
      end
   end

   assign wr_c      = '{wr_en: bus.chipselect & ~bus.write_n, addr: bus.address, data: bus.writedata};
   assign unused_wr = ^wr_c.data;
   assign clr_c     = (wr_c.wr_en && (wr_c.addr == ADDR_EDGE)) ? wr_c.data[WIDTH-1:0] : '0;

   // A new edge event outranks a simultaneous write-1-to-clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mask_q <= '0;
         edge_q <= '0;
      end else begin
         if (wr_c.wr_en && (wr_c.addr == ADDR_MASK)) begin
            mask_q <= wr_c.data[WIDTH-1:0];
         end
         edge_q <= (edge_q & ~clr_c) | edge_ev_c;
      end
   end

   always_comb begin
      rd_c = '0;
      case (bus.address)
         ADDR_DATA: rd_c = DATA_W'(db);
         ADDR_DIR:  rd_c = '0;
         ADDR_MASK: rd_c = DATA_W'(mask_q);
         ADDR_EDGE: rd_c = DATA_W'(edge_q);
         default:   rd_c = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.readdata <= '0;
      end else begin
         bus.readdata <= rd_c;
      end
   end

   assign irq = |(edge_q & mask_q);

endmodule

// File: tb/tb_pb_irq_pio.sv
// Bench for pb_irq_pio: three configurations against a sliding-window reference model.
module tb_pb_irq_pio;
   import pb_irq_pio_pkg::*;

   logic clk     = 1'b0;
   logic reset_n = 1'b1;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Port 0 drives instances a and b, port 1 drives instance c.
   logic [3:0]  in_p   [2];
   logic [1:0]  addr_p [2];
   logic        cs_p   [2];
   logic        wn_p   [2];
   logic [31:0] wd_p   [2];

   pb_irq_pio_if bus_a ();
   pb_irq_pio_if bus_b ();
   pb_irq_pio_if bus_c ();

   assign bus_a.address = addr_p[0];  assign bus_a.chipselect = cs_p[0];
   assign bus_a.write_n = wn_p[0];    assign bus_a.writedata  = wd_p[0];
   assign bus_b.address = addr_p[0];  assign bus_b.chipselect = cs_p[0];
   assign bus_b.write_n = wn_p[0];    assign bus_b.writedata  = wd_p[0];
   assign bus_c.address = addr_p[1];  assign bus_c.chipselect = cs_p[1];
   assign bus_c.write_n = wn_p[1];    assign bus_c.writedata  = wd_p[1];

   logic        irq_a, irq_b, irq_c;
   logic [31:0] rd_v  [3];
   logic        irq_v [3];
   assign rd_v[0] = bus_a.readdata;  assign irq_v[0] = irq_a;
   assign rd_v[1] = bus_b.readdata;  assign irq_v[1] = irq_b;
   assign rd_v[2] = bus_c.readdata;  assign irq_v[2] = irq_c;

   pb_irq_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)) u_a (
      .clk(clk), .reset_n(reset_n), .bus(bus_a), .in_port(in_p[0]), .irq(irq_a));
   pb_irq_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) u_b (
      .clk(clk), .reset_n(reset_n), .bus(bus_b), .in_port(in_p[0]), .irq(irq_b));
   pb_irq_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)) u_c (
      .clk(clk), .reset_n(reset_n), .bus(bus_c), .in_port(in_p[1]), .irq(irq_c));

   function automatic int dc_of(input int k);
      return (k == 2) ? 0 : 4;
   endfunction

   function automatic int et_of(input int k);
      return (k == 0) ? 1 : ((k == 1) ? 0 : 2);
   endfunction

   task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] want);
      vectors++;
      if (act !== want) begin
         miscompares++;
         $display("FAIL %s inst=%0d act=%h want=%h t=%0t", name, inst, act, want, $time);
      end
   endtask

   // Model: samp[k][j] is in_port sampled j+1 edges ago; the filtered bit flips once the
   // synchronised input has disagreed with it on the last DEBOUNCE_CYCLES edges.
   logic [3:0]  samp  [3][8];
   logic [3:0]  db_m  [3];
   logic [3:0]  mask_m[3];
   logic [3:0]  ec_m  [3];
   logic [31:0] rd_m  [3];

   initial begin
      for (int k = 0; k < 3; k++) begin
         db_m[k] = '0; mask_m[k] = '0; ec_m[k] = '0; rd_m[k] = '0;
         for (int j = 0; j < 8; j++) samp[k][j] = '0;
      end
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) begin
            for (int k = 0; k < 3; k++) begin
               db_m[k] = '0; mask_m[k] = '0; ec_m[k] = '0; rd_m[k] = '0;
               for (int j = 0; j < 8; j++) samp[k][j] = '0;
            end
         end else begin
            for (int k = 0; k < 3; k++) begin
               int p;
               logic [3:0] nd, ev, clr;
               logic we;
               p = (k == 2) ? 1 : 0;
               case (addr_p[p])
                  2'd0:    rd_m[k] = {28'h0, db_m[k]};
                  2'd1:    rd_m[k] = 32'h0;
                  2'd2:    rd_m[k] = {28'h0, mask_m[k]};
                  default: rd_m[k] = {28'h0, ec_m[k]};
               endcase
               if (dc_of(k) == 0) begin
                  nd = samp[k][1];
               end else begin
                  for (int i = 0; i < 4; i++) begin
                     logic all_diff;
                     all_diff = 1'b1;
                     for (int j = 1; j <= dc_of(k); j++)
                        if (samp[k][j][i] == db_m[k][i]) all_diff = 1'b0;
                     nd[i] = all_diff ? ~db_m[k][i] : db_m[k][i];
                  end
               end
               case (et_of(k))
                  0:       ev = nd & ~db_m[k];
                  1:       ev = ~nd & db_m[k];
                  default: ev = nd ^ db_m[k];
               endcase
               we  = cs_p[p] & ~wn_p[p];
               clr = (we && addr_p[p] == 2'd3) ? wd_p[p][3:0] : 4'h0;
               if (we && addr_p[p] == 2'd2) mask_m[k] = wd_p[p][3:0];
               ec_m[k] = (ec_m[k] & ~clr) | ev;
               db_m[k] = nd;
               for (int j = 7; j > 0; j--) samp[k][j] = samp[k][j-1];
               samp[k][0] = in_p[p];
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            check("readdata", k, rd_v[k], rd_m[k]);
            check("irq", k, 32'(irq_v[k]), 32'(|(ec_m[k] & mask_m[k])));
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input int p, input logic [1:0] a, input logic [31:0] d);
      addr_p[p] = a; wd_p[p] = d; cs_p[p] = 1'b1; wn_p[p] = 1'b0;
      step(1);
      cs_p[p] = 1'b0; wn_p[p] = 1'b1;
   endtask

   task automatic rd(input int p, input logic [1:0] a);
      addr_p[p] = a;
      step(1);
   endtask

   initial begin
      for (int p = 0; p < 2; p++) begin
         in_p[p] = 4'hF; addr_p[p] = 2'd0; cs_p[p] = 1'b0; wn_p[p] = 1'b1; wd_p[p] = '0;
      end
      #2 reset_n = 1'b0;
      step(3);
      check("rst_rdata", 0, rd_v[0], 32'h0);
      check("rst_irq", 0, 32'(irq_a), 32'h0);
      reset_n = 1'b1;
      check("rel_rdata", 0, rd_v[0], 32'h0);
      step(8);
      check("data_settled", 0, rd_v[0], 32'h0000000F);
      rd(0, 2'd3);
      check("no_rise_capture", 0, rd_v[0], 32'h0);

      // Short glitch is filtered out
      in_p[0] = 4'hE; step(3); in_p[0] = 4'hF; step(10);
      rd(0, 2'd0);
      check("glitch_data", 0, rd_v[0], 32'h0000000F);
      rd(0, 2'd3);
      check("glitch_edge", 0, rd_v[0], 32'h0);

      // Long press
      in_p[0] = 4'hE; step(8);
      rd(0, 2'd0);
      check("press_data", 0, rd_v[0], 32'h0000000E);
      rd(0, 2'd3);
      check("press_edge", 0, rd_v[0], 32'h00000001);

      // DATA and DIRECTION ignore writes
      wr(0, 2'd1, 32'hFFFF_FFFF); wr(0, 2'd0, 32'h0);
      rd(0, 2'd1);
      check("dir_reads_zero", 0, rd_v[0], 32'h0);
      rd(0, 2'd0);
      check("data_ro", 0, rd_v[0], 32'h0000000E);

      // Mask raises irq, W1C drops it
      wr(0, 2'd2, 32'h1);
      check("irq_on_mask", 0, 32'(irq_a), 32'h1);
      wr(0, 2'd3, 32'h1);
      check("irq_on_clear", 0, 32'(irq_a), 32'h0);
      rd(0, 2'd3);
      check("edge_cleared", 0, rd_v[0], 32'h0);

      // W1C lands on the same edge as bit 1's falling event
      in_p[0] = 4'hC; step(5);
      wr(0, 2'd3, 32'h2);
      rd(0, 2'd3);
      check("set_wins", 0, rd_v[0], 32'h00000002);
      wr(0, 2'd3, 32'h0);
      rd(0, 2'd3);
      check("w1c_zero_noop", 0, rd_v[0], 32'h00000002);
      wr(0, 2'd3, 32'h2);
      rd(0, 2'd3);
      check("w1c_bit1", 0, rd_v[0], 32'h0);

      // Bypass, any-edge instance
      wr(1, 2'd3, 32'hF);
      rd(1, 2'd3);
      check("c_cleared", 2, rd_v[2], 32'h0);
      rd(1, 2'd0);
      in_p[1] = 4'h7; step(2);
      in_p[1] = 4'hF; step(1);
      check("c_lag_e3", 2, rd_v[2], 32'h0000000F);
      step(1);
      check("c_lag_e4", 2, rd_v[2], 32'h00000007);
      step(1);
      check("c_lag_e5", 2, rd_v[2], 32'h00000007);
      step(1);
      check("c_lag_e6", 2, rd_v[2], 32'h0000000F);
      rd(1, 2'd3);
      check("c_any_edge", 2, rd_v[2], 32'h00000008);

      // Reset mid-debounce with irq asserted
      wr(0, 2'd2, 32'hF);
      in_p[0] = 4'h8; step(8);
      check("irq_before_rst", 0, 32'(irq_a), 32'h1);
      in_p[0] = 4'h0; step(4);
      reset_n = 1'b0;
      #1;
      check("mid_rst_rdata", 0, rd_v[0], 32'h0);
      check("mid_rst_irq", 0, 32'(irq_a), 32'h0);
      in_p[0] = 4'hF; addr_p[0] = 2'd0;
      step(3);
      reset_n = 1'b1;
      step(6);
      check("post_rst_e6", 0, rd_v[0], 32'h0);
      step(1);
      check("post_rst_e7", 0, rd_v[0], 32'h0000000F);
      rd(0, 2'd2);
      check("post_rst_mask", 0, rd_v[0], 32'h0);
      rd(0, 2'd3);
      check("post_rst_edge", 0, rd_v[0], 32'h0);
      step(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
